regfile_debug_dumper: RTL and testbench

- Debug-path consumer of the register file's debug read port (read_regDebug / out_regDebug).
- On a start request it freezes the normal operand reads by holding Debug_on high, then walks register addresses 0..NUM_REGS-1 and captures each 32-bit word.
- Each word is streamed MSB-byte-first over a valid/ready byte interface to the UART TX block of the debug unit.

---
 rtl/regfile_debug_dumper_pkg.sv | 28 ++
 rtl/regfile_debug_dumper_if.sv | 11 +
 rtl/regfile_debug_dumper_word_byte_serializer.sv | 61 ++++++
 rtl/regfile_debug_dumper.sv | 136 +++++++++++++
 tb/tb_regfile_debug_dumper.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_debug_dumper_pkg.sv
// Shared definitions for the register-file debug dumper: state encoding,
// default geometry and stream-length helpers used by the UART framing side.
package regfile_debug_dumper_pkg;

  localparam int NUM_REGS_DEF   = 32;
  localparam int ADDR_W_DEF     = 5;
  localparam int DATA_W_DEF     = 32;
  localparam int BYTES_PER_WORD = DATA_W_DEF / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_SEND,
    ST_CSUM,
    ST_FIN
  } dump_state_e;

  function automatic int bytesPerWord(input int dataW);
    return dataW / 8;
  endfunction

  // Checksum builds append exactly one trailing byte to the stream.
  function automatic int streamBytes(input int numRegs, input int dataW, input bit csumEn);
    return numRegs * bytesPerWord(dataW) + (csumEn ? 1 : 0);
  endfunction

endpackage

// File: rtl/regfile_debug_dumper_if.sv
// Byte-wide valid/ready stream from the debug dumper to the UART TX block.
interface regfile_debug_dumper_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/regfile_debug_dumper_word_byte_serializer.sv
// Loads one register word and emits it MSB-byte-first under valid/ready,
// pulsing last_byte_done_o on the cycle the final byte is accepted.
module regfile_debug_dumper_word_byte_serializer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [7:0]        data_o,
  output logic              last_byte_done_o
);

  localparam int BPW   = DATA_W / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BPW - 1);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              xfer;

  assign xfer = valid_q && ready_i;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_i) begin
      shift_d = word_i;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (xfer) begin
      shift_d = shift_q << 8;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == LAST_CNT) begin
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o          = valid_q;
  assign data_o           = shift_q[DATA_W-1 -: 8];
  assign last_byte_done_o = xfer && (cnt_q == LAST_CNT);

endmodule

// File: rtl/regfile_debug_dumper.sv
// Walks the register file's debug read port and streams every word over the
// byte interface. Define DUMP_CHECKSUM_EN to append an XOR checksum byte.
module regfile_debug_dumper
  import regfile_debug_dumper_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  Debug_on,
  output logic [ADDR_W-1:0]     read_regDebug,
  input  logic [DATA_W-1:0]     regDebug_in,
  regfile_debug_dumper_if.master tx,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  dump_state_e       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              debug_on_q;
  logic              busy_q;
  logic              done_q;

  logic              load_word;
  logic              ser_valid;
  logic [7:0]        ser_data;
  logic              last_byte_done;

  // The register file answers on the negedge, so the word is valid by the end of WAIT.
  assign load_word = (state_q == ST_WAIT);

  regfile_debug_dumper_word_byte_serializer #(
    .DATA_W(DATA_W)
  ) u_serializer (
    .clk              (clk),
    .rst              (rst),
    .load_i           (load_word),
    .word_i           (regDebug_in),
    .ready_i          (tx.tx_ready),
    .valid_o          (ser_valid),
    .data_o           (ser_data),
    .last_byte_done_o (last_byte_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      debug_on_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_ADDR;
            addr_q     <= '0;
            debug_on_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_ADDR: state_q <= ST_WAIT;
        ST_WAIT: state_q <= ST_SEND;
        ST_SEND: begin
          if (last_byte_done) begin
            if (addr_q == LAST_ADDR) begin
`ifdef DUMP_CHECKSUM_EN
              state_q    <= ST_CSUM;
`else
              state_q    <= ST_FIN;
              debug_on_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
`endif
            end else begin
              addr_q  <= addr_q + 1'b1;
              state_q <= ST_ADDR;
            end
          end
        end
`ifdef DUMP_CHECKSUM_EN
        ST_CSUM: begin
          if (tx.tx_ready) begin
            state_q    <= ST_FIN;
            debug_on_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end
        end
`endif
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef DUMP_CHECKSUM_EN
  logic [7:0] csum_q;
  logic       csum_valid_q;

  // Running XOR of accepted data bytes; presented as one extra byte after the last word.
  always_ff @(posedge clk) begin
    if (rst || state_q == ST_IDLE) begin
      csum_q       <= '0;
      csum_valid_q <= 1'b0;
    end else begin
      if (ser_valid && tx.tx_ready) begin
        csum_q <= csum_q ^ ser_data;
      end
      if (state_q == ST_SEND && last_byte_done && addr_q == LAST_ADDR) begin
        csum_valid_q <= 1'b1;
      end else if (csum_valid_q && tx.tx_ready) begin
        csum_valid_q <= 1'b0;
      end
    end
  end

  assign tx.tx_valid = ser_valid | csum_valid_q;
  assign tx.tx_data  = csum_valid_q ? csum_q : ser_data;
`else
  assign tx.tx_valid = ser_valid;
  assign tx.tx_data  = ser_data;
`endif

  assign Debug_on      = debug_on_q;
  assign read_regDebug = addr_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_regfile_debug_dumper.sv
// Self-checking bench for regfile_debug_dumper: random register contents and
// tx_ready patterns compared against a byte-stream model of the dump.
`timescale 1ns/1ps
module tb_regfile_debug_dumper;
  import regfile_debug_dumper_pkg::*;

  localparam int NREGS = 32;
  localparam int BPW   = 4;
`ifdef DUMP_CHECKSUM_EN
  localparam int CSUM_EN = 1;
`else
  localparam int CSUM_EN = 0;
`endif
  localparam int STREAM_LEN = NREGS * BPW + CSUM_EN;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        Debug_on;
  logic        busy;
  logic        done;
  logic [4:0]  read_regDebug;
  logic [31:0] regDebug_in;

  regfile_debug_dumper_if tx();

  regfile_debug_dumper dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .Debug_on      (Debug_on),
    .read_regDebug (read_regDebug),
    .regDebug_in   (regDebug_in),
    .tx            (tx),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Register file model with a negedge debug read.
  logic [31:0] regs [NREGS];
  always @(negedge clk) regDebug_in <= regs[read_regDebug];

  int checks = 0;
  int errors = 0;
  int sampleCnt = 0;

  logic       obsValid, obsDbg, obsBusy, obsDone;
  logic [7:0] obsData;
  logic [4:0] obsAddr;
  logic       prevValid, prevXfer, prevRst;
  logic [7:0] prevData;

  logic [7:0] got[$];
  logic [7:0] expStream[$];
  int doneSample, startSample, donePulses, dbgCycles, addrErr, hsErr, bpHeld;
  bit rstSeen;

  int         pinIdx[12] = '{0, 1, 2, 3, 36, 37, 38, 39, 124, 125, 126, 127};
  logic [7:0] pinVal[12] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h87, 8'h65, 8'h43, 8'h21,
                             8'h00, 8'h00, 8'h00, 8'h2A};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic void buildExpected();
    logic [7:0] b;
    logic [7:0] x;
    expStream.delete();
    x = 8'h00;
    for (int r = 0; r < NREGS; r++) begin
      for (int k = BPW - 1; k >= 0; k--) begin
        b = 8'(regs[r] >> (8 * k));
        expStream.push_back(b);
        x = x ^ b;
      end
    end
    if (CSUM_EN != 0) expStream.push_back(x);
  endfunction

  function automatic logic [7:0] getByte(input int i);
    if (i < got.size()) return got[i];
    return 8'hxx;
  endfunction

  function automatic int streamDiff();
    int d = 0;
    int n = (got.size() < expStream.size()) ? got.size() : expStream.size();
    d = (got.size() > expStream.size()) ? got.size() - expStream.size() : expStream.size() - got.size();
    for (int i = 0; i < n; i++) if (got[i] !== expStream[i]) d++;
    return d;
  endfunction

  task automatic sampleCycle();
    @(negedge clk);
    sampleCnt++;
    obsValid = tx.tx_valid;
    obsData  = tx.tx_data;
    obsDbg   = Debug_on;
    obsBusy  = busy;
    obsDone  = done;
    obsAddr  = read_regDebug;
    if (prevValid === 1'b1 && !prevXfer && !prevRst && !(obsValid === 1'b1 && obsData === prevData)) hsErr++;
    if (obsDone === 1'b1) begin
      donePulses++;
      if (doneSample < 0) doneSample = sampleCnt;
    end
    if (obsDbg === 1'b1) begin
      dbgCycles++;
      if (got.size() < NREGS * BPW && obsAddr !== 5'(got.size() / BPW)) addrErr++;
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic rs);
    start       = s;
    tx.tx_ready = r;
    rst         = rs;
    prevValid   = obsValid;
    prevData    = obsData;
    prevRst     = rs;
    prevXfer    = (obsValid === 1'b1) && r && !rs;
    if (prevXfer) got.push_back(obsData);
  endtask

  task automatic runDump(input int restartAt, input int bpAt, input bit randReady, input int rstAt);
    int  k = 0;
    int  bpLeft = 0;
    bit  bpDone = 0;
    logic s, r, rs;
    got.delete();
    donePulses = 0; doneSample = -1; dbgCycles = 0; addrErr = 0; hsErr = 0; bpHeld = 0; rstSeen = 0;
    buildExpected();
    sampleCycle();
    applyStimulus(1'b1, 1'b1, 1'b0);
    startSample = sampleCnt;
    while (doneSample < 0 && k < 2000 && !rstSeen) begin
      sampleCycle();
      k++;
      s = (k == restartAt);
      r = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (bpAt >= 0 && !bpDone && got.size() == bpAt && obsValid === 1'b1) begin
        bpLeft = 5;
        bpDone = 1;
      end
      if (bpLeft > 0) begin
        r = 1'b0;
        bpLeft--;
        if (obsValid === 1'b1 && obsData === expStream[bpAt]) bpHeld++;
      end
      rs = (rstAt >= 0 && got.size() == rstAt && obsValid === 1'b1);
      if (rs) rstSeen = 1;
      applyStimulus(s, r, rs);
    end
    if (!rstSeen) repeat (10) begin
      sampleCycle();
      applyStimulus(1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
    rst = 1'b1; start = 1'b0; tx.tx_ready = 1'b0;
    obsValid = 1'b0; obsData = 8'h00; prevValid = 1'b0; prevXfer = 1'b0; prevRst = 1'b1; prevData = 8'h00;

    repeat (3) begin
      sampleCycle();
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    sampleCycle();
    checkOutput("rst_tx_valid", obsValid, 0);
    checkOutput("rst_tx_data", obsData, 0);
    checkOutput("rst_debug_on", obsDbg, 0);
    checkOutput("rst_busy", obsBusy, 0);
    checkOutput("rst_done", obsDone, 0);
    checkOutput("rst_addr", obsAddr, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);

    $display("[TB] dump A: pinned registers, ready high, start re-pulsed mid-dump");
    regs[0] = 32'h0000_0001; regs[1] = 32'h0000_0004; regs[9] = 32'h8765_4321; regs[31] = 32'h0000_002A;
    runDump(50, -1, 1'b0, -1);
    checkOutput("A_done_seen", doneSample >= 0, 1);
    checkOutput("A_done_latency", doneSample - startSample, 193 + CSUM_EN);
    checkOutput("A_debug_cycles", dbgCycles, 192 + CSUM_EN);
    checkOutput("A_done_pulses", donePulses, 1);
    checkOutput("A_len", got.size(), STREAM_LEN);
    for (int i = 0; i < 12; i++) checkOutput($sformatf("A_byte%0d", pinIdx[i]), getByte(pinIdx[i]), pinVal[i]);
    checkOutput("A_stream", streamDiff(), 0);
    checkOutput("A_addr_track", addrErr, 0);
    checkOutput("A_handshake", hsErr, 0);

    $display("[TB] dump B: 5-cycle backpressure on byte 2 of reg1");
    for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
    regs[1] = 32'h0000_0004;
    runDump(-1, 6, 1'b0, -1);
    checkOutput("B_bp_held", bpHeld, 5);
    checkOutput("B_bp_byte", expStream[6], 8'h00);
    checkOutput("B_len", got.size(), STREAM_LEN);
    checkOutput("B_stream", streamDiff(), 0);
    checkOutput("B_handshake", hsErr, 0);
    checkOutput("B_done_latency", doneSample - startSample, 198 + CSUM_EN);

    $display("[TB] dump C: random data, random tx_ready");
    for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
    runDump(-1, -1, 1'b1, -1);
    checkOutput("C_len", got.size(), STREAM_LEN);
    checkOutput("C_stream", streamDiff(), 0);
    checkOutput("C_handshake", hsErr, 0);
    checkOutput("C_addr_track", addrErr, 0);
    checkOutput("C_done_pulses", donePulses, 1);

    $display("[TB] dump D: reset during SEND of reg10");
    for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
    regs[0] = 32'h0000_0001;
    runDump(-1, -1, 1'b0, 41);
    checkOutput("D_rst_hit", rstSeen, 1);
    sampleCycle();
    checkOutput("D_tx_valid", obsValid, 0);
    checkOutput("D_debug_on", obsDbg, 0);
    checkOutput("D_busy", obsBusy, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);

    $display("[TB] dump E: restart after reset");
    runDump(-1, -1, 1'b0, -1);
    checkOutput("E_byte0", getByte(0), 8'h00);
    checkOutput("E_byte3", getByte(3), 8'h01);
    checkOutput("E_len", got.size(), STREAM_LEN);
    checkOutput("E_stream", streamDiff(), 0);

`ifdef DUMP_CHECKSUM_EN
    $display("[TB] dump F: checksum over a single non-zero register");
    for (int i = 0; i < NREGS; i++) regs[i] = 32'h0;
    regs[9] = 32'h8765_4321;
    runDump(-1, -1, 1'b0, -1);
    checkOutput("F_len", got.size(), 129);
    checkOutput("F_csum", getByte(128), 8'h80);
    checkOutput("F_done_pulses", donePulses, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
